lcd_bus_writer: RTL and testbench
=================================

# lcd_bus_writer

Parametrised, buffered successor to the single-shot LCD write path. Accepts numbered commands over a valid/ready interface, queues them in a FIFO, and plays each out as a complete 8080-style parallel write cycle (CS/RS/WR/RD/data) with programmable setup, strobe and hold lengths. Sits between the keyboard/control logic and the LCD pins, and gates every pin low when panel power is off.

## Interface
Parameters:
- DATA_W, 8 — LCD data bus width (8 or 16)
- ADDR_W, 3 — command number width
- FIFO_DEPTH, 8 — queued commands; power of two, at least 2
- SETUP_CYC, 1 — cycles CS/RS/data are valid before WR falls; at least 1
- STROBE_CYC, 1 — cycles WR is held low; at least 1
- HOLD_CYC, 2 — cycles CS stays low after WR rises; at least 1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- commData  in  DATA_W  command payload
- commAddr  in  ADDR_W  command number: 2 = data write (RS=1), 3 = instruction write (RS=0), any other value = no-op
- wrEn  in  1  push request (valid)
- wrRdy  out  1  FIFO can accept; a push occurs on an edge where wrEn & wrRdy
- lcdPwr  in  1  panel power enable
- busy  out  1  FIFO non-empty or FSM not IDLE
- fifoLevel  out  $clog2(FIFO_DEPTH)+1  entries stored
- dispData  out  DATA_W  LCD data bus
- lcdRs, lcdWr, lcdRd, lcdCs  out  1 each  LCD control pins

## Operation
- Entry = {commAddr, commData}. Only addresses 2 and 3 are queued; other addresses complete the handshake and are discarded (no bus cycle, level unchanged).
- wrRdy = lcdPwr & ~full; it has no same-cycle pop bypass.
- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE. IDLE with FIFO non-empty pops the head and enters SETUP. One down-counter is loaded on each state entry.
- Pin drive per state (lcdPwr=1): IDLE: CS=1, WR=1, data=0, RS holds its last value. SETUP: CS=0, WR=1, RS/data from the popped entry. STROBE: CS=0, WR=0. HOLD: CS=0, WR=1, data held. lcdRd is always 1.
- Pin registers reset to: CS=1, WR=1, RD=1, RS=1, data=0. The FSM resets to IDLE with the FIFO empty.
- lcdPwr=0: all LCD pins are forced to 0 combinationally. The FIFO is flushed, the FSM is forced to IDLE, and wrRdy=0. When lcdPwr returns to 1, the pins resume their IDLE values on the next cycle.
- Reset mid-transaction: the FSM is aborted immediately, and CS/WR go to 1 asynchronously.

## Timing
- Push at edge E0 into an empty FIFO with FSM IDLE: SETUP begins at E1; CS falls and data/RS become valid after E1.
- WR falls at E1+SETUP_CYC, rises at E1+SETUP_CYC+STROBE_CYC, and CS rises at E1+SETUP_CYC+STROBE_CYC+HOLD_CYC.
- Non-burst spacing: at least 1 IDLE cycle with CS=1 between transactions.
- Throughput, non-burst: one write per SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles.
- Push and pop on the same edge: fifoLevel is unchanged. Full with a simultaneous pop: the push is still refused.
- fifoLevel and busy are registered, and update on the edge of the push or pop.

## Configuration
- LCD_BURST_EN defined: from HOLD with the FIFO non-empty, the FSM pops directly into SETUP. CS stays low across back-to-back writes, and RS/data may change at the SETUP entry. Throughput is one write per S+W+H cycles.
- LCD_BURST_EN undefined: the FSM always returns to IDLE, so CS pulses high for at least 1 cycle between writes.

## Test plan
- Reset, lcdPwr=1, defaults: pins read CS=1, WR=1, RD=1, RS=1, data=0, and wrRdy=1.
- Single push addr=3, data=0xA5: CS low for 4 cycles, WR low for exactly 1 cycle (3rd cycle after the push), RS=0, dispData=0xA5. busy then drops.
- Push addr=5: handshake accepted, no CS activity, fifoLevel stays 0.
- Push 9 entries back-to-back with FIFO_DEPTH=8 and a stalled bus: wrRdy drops at level 8. All 8 queued entries then emerge in order with correct RS (2→1, 3→0).
- Drop lcdPwr mid-STROBE: all pins 0 the same cycle and fifoLevel=0 next edge. Restore power: IDLE pins and no spurious WR pulse.
- Two queued writes: with LCD_BURST_EN, CS stays continuously low for 8 cycles. Without it, a 1-cycle CS-high gap appears.

Source files
------------

// File: rtl/lcd_bus_writer.sv
// ---------------------------------------------------------------------------
// lcd_bus_writer
//
// Buffered LCD write path. Commands arrive over a valid/ready handshake and
// are queued in a small FIFO. Each queued entry is played out as one complete
// 8080-style parallel write cycle (CS/RS/WR/RD/data). The setup, strobe and
// hold phases have programmable lengths. Every LCD pin is gated low while
// panel power is off.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   commData      command payload (DATA_W bits)
//   commAddr      command number: 2 = data write (RS=1),
//                 3 = instruction write (RS=0), anything else = no-op
//   wrEn / wrRdy  push handshake; a push happens on an edge with wrEn & wrRdy
//   lcdPwr        panel power enable; 0 flushes the FIFO and idles the FSM
//   busy          registered: FIFO non-empty or a bus cycle in progress
//   fifoLevel     registered count of queued entries
//   dispData      LCD data bus
//   lcdRs, lcdWr, lcdRd, lcdCs   LCD control pins
//
// Build option:
//   LCD_BURST_EN  when defined, a queued entry is popped straight from HOLD
//                 into SETUP, so CS stays low across back-to-back writes.
//                 When undefined, CS always returns high for at least one
//                 IDLE cycle between writes.
// ---------------------------------------------------------------------------
module lcd_bus_writer #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 3,
   parameter int FIFO_DEPTH = 8,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 1,
   parameter int HOLD_CYC   = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_W-1:0]           commData,
   input  logic [ADDR_W-1:0]           commAddr,
   input  logic                        wrEn,
   output logic                        wrRdy,
   input  logic                        lcdPwr,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifoLevel,
   output logic [DATA_W-1:0]           dispData,
   output logic                        lcdRs,
   output logic                        lcdWr,
   output logic                        lcdRd,
   output logic                        lcdCs
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   // One down-counter serves all three timed phases, so it is sized for the
   // longest of them; it is loaded with (length - 1) on phase entry.
   localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                            ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                            : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_STROBE = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   localparam logic [ADDR_W-1:0] ADDR_DATA = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_INST = ADDR_W'(3);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]        state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]  level_q,  level_d;
   logic              busy_q,   busy_d;

   logic              cs_q,     cs_d;
   logic              wr_q,     wr_d;
   logic              rs_q,     rs_d;
   logic [DATA_W-1:0] data_q,   data_d;

   // Entry layout: {rs, data}. The command number reduces to the RS bit
   // because only addresses 2 and 3 are ever stored.
   logic [DATA_W:0]   fifo_mem_q [FIFO_DEPTH];
   logic [DATA_W:0]   head;

   logic              cmd_is_data;
   logic              cmd_valid;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop;
   logic              cnt_done;

   // ------------------------------------------------------------------------
   // Handshake and FIFO status
   // ------------------------------------------------------------------------
   assign cmd_is_data = (commAddr == ADDR_DATA);
   assign cmd_valid   = cmd_is_data || (commAddr == ADDR_INST);

   assign fifo_empty  = (level_q == '0);
   assign fifo_full   = (level_q == LVL_W'(FIFO_DEPTH));

   // No pop bypass: a full FIFO refuses pushes even on the edge it pops.
   assign wrRdy       = lcdPwr & ~fifo_full;

   // No-op commands complete the handshake but are never stored.
   assign push        = wrEn & wrRdy & cmd_valid;

   assign head        = fifo_mem_q[rd_ptr_q];
   assign cnt_done    = (cnt_q == '0);

   // ------------------------------------------------------------------------
   // Bus-cycle FSM
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;

      if (!lcdPwr) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ST_SETUP;
                  cnt_d   = SETUP_LD;
               end
            end
            ST_SETUP: begin
               if (cnt_done) begin
                  state_d = ST_STROBE;
                  cnt_d   = STROBE_LD;
               end else begin
                  cnt_d   = cnt_q - CNT_W'(1);
               end
            end
            ST_STROBE: begin
               if (cnt_done) begin
                  state_d = ST_HOLD;
                  cnt_d   = HOLD_LD;
               end else begin
                  cnt_d   = cnt_q - CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt_done) begin
`ifdef LCD_BURST_EN
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     state_d = ST_SETUP;
                     cnt_d   = SETUP_LD;
                  end else begin
                     state_d = ST_IDLE;
                  end
`else
                  state_d = ST_IDLE;
`endif
               end else begin
                  cnt_d   = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FIFO bookkeeping
   // ------------------------------------------------------------------------
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;

      if (!lcdPwr) begin
         // Power loss flushes everything queued.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end

      busy_d = (level_d != '0) || (state_d != ST_IDLE);
   end

   // ------------------------------------------------------------------------
   // Pin drive
   // Pins are registered from the next state so they change on the same edge
   // the FSM enters a phase.
   // ------------------------------------------------------------------------
   always_comb begin
      cs_d   = cs_q;
      wr_d   = wr_q;
      rs_d   = rs_q;
      data_d = data_q;

      case (state_d)
         ST_IDLE: begin
            // RS deliberately keeps its last value while idle.
            cs_d   = 1'b1;
            wr_d   = 1'b1;
            data_d = '0;
         end
         ST_SETUP: begin
            cs_d = 1'b0;
            wr_d = 1'b1;
            if (pop) begin
               rs_d   = head[DATA_W];
               data_d = head[DATA_W-1:0];
            end
         end
         ST_STROBE: begin
            cs_d = 1'b0;
            wr_d = 1'b0;
         end
         ST_HOLD: begin
            cs_d = 1'b0;
            wr_d = 1'b1;
         end
         default: begin
            cs_d   = 1'b1;
            wr_d   = 1'b1;
            data_d = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         busy_q   <= 1'b0;
         cs_q     <= 1'b1;
         wr_q     <= 1'b1;
         rs_q     <= 1'b1;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         busy_q   <= busy_d;
         cs_q     <= cs_d;
         wr_q     <= wr_d;
         rs_q     <= rs_d;
         data_q   <= data_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {cmd_is_data, commData};
      end
   end

   // ------------------------------------------------------------------------
   // Outputs; power-off gating is combinational so pins drop immediately.
   // ------------------------------------------------------------------------
   assign busy      = busy_q;
   assign fifoLevel = level_q;
   assign lcdCs     = lcdPwr & cs_q;
   assign lcdWr     = lcdPwr & wr_q;
   assign lcdRs     = lcdPwr & rs_q;
   assign lcdRd     = lcdPwr;
   assign dispData  = lcdPwr ? data_q : '0;

endmodule

// File: tb/tb_lcd_bus_writer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_lcd_bus_writer
//
// Directed sequence with randomised payloads. Expected pin waveforms are
// derived from the list of accepted transactions: each CS-low window is cut
// into slots of SETUP+STROBE+HOLD cycles, one per write, with WR low in the
// strobe part of the slot and RS/data equal to that write's entry.
// ---------------------------------------------------------------------------
module tb_lcd_bus_writer;

   localparam int DATA_W     = 8;
   localparam int ADDR_W     = 3;
   localparam int FIFO_DEPTH = 8;
   localparam int S          = 1;
   localparam int W          = 1;
   localparam int H          = 2;
   localparam int P          = S + W + H;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;
`ifdef LCD_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] commData;
   logic [ADDR_W-1:0] commAddr;
   logic              wrEn;
   logic              wrRdy;
   logic              lcdPwr;
   logic              busy;
   logic [LW-1:0]     fifoLevel;
   logic [DATA_W-1:0] dispData;
   logic              lcdRs, lcdWr, lcdRd, lcdCs;

   lcd_bus_writer #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .SETUP_CYC (S),
      .STROBE_CYC(W),
      .HOLD_CYC  (H)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .commData (commData),
      .commAddr (commAddr),
      .wrEn     (wrEn),
      .wrRdy    (wrRdy),
      .lcdPwr   (lcdPwr),
      .busy     (busy),
      .fifoLevel(fifoLevel),
      .dispData (dispData),
      .lcdRs    (lcdRs),
      .lcdWr    (lcdWr),
      .lcdRd    (lcdRd),
      .lcdCs    (lcdCs)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              cs;
      logic              wr;
      logic              rd;
      logic              rs;
      logic [DATA_W-1:0] data;
   } samp_t;

   typedef struct packed {
      logic              rs;
      logic [DATA_W-1:0] data;
   } txn_t;

   samp_t trace [$];
   txn_t  exp_q [$];
   int    checks   = 0;
   int    failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and record the pins 1 ns after the edge.
   task automatic step();
      samp_t s;
      @(posedge clk);
      #1;
      s.cs   = lcdCs;
      s.wr   = lcdWr;
      s.rd   = lcdRd;
      s.rs   = lcdRs;
      s.data = dispData;
      trace.push_back(s);
   endtask

   // Present one command for one edge; record it if it will be queued.
   task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      txn_t t;
      commAddr = a;
      commData = d;
      wrEn     = 1'b1;
      if (wrRdy && (a == 2 || a == 3)) begin
         t.rs   = (a == 2);
         t.data = d;
         exp_q.push_back(t);
      end
      step();
      wrEn = 1'b0;
   endtask

   // Check the recorded trace against the expected transaction list.
   task automatic analyse(input string tag, output int nruns, output int first_start,
                          output int gap);
      int i, j, rs0, n, off, t, last_end;
      nruns       = 0;
      first_start = -1;
      gap         = -1;
      last_end    = -1;
      i           = 0;
      while (i < trace.size()) begin
         if (trace[i].cs) begin
            chk({tag, "_idle_wr"},   32'(trace[i].wr),   32'd1);
            chk({tag, "_idle_rd"},   32'(trace[i].rd),   32'd1);
            chk({tag, "_idle_data"}, 32'(trace[i].data), 32'd0);
            i++;
         end else begin
            rs0 = i;
            while (i < trace.size() && !trace[i].cs) i++;
            n = i - rs0;
            if (nruns == 0) first_start = rs0;
            if (nruns == 1) gap = rs0 - last_end;
            nruns++;
            last_end = i;
            chk({tag, "_cs_len"}, 32'(n), BURST ? 32'((n / P) * P) : 32'(P));
            for (j = rs0; j < i; j++) begin
               off = (j - rs0) % P;
               t   = (j - rs0) / P;
               chk({tag, "_wr"}, 32'(trace[j].wr), (off >= S && off < S + W) ? 32'd0 : 32'd1);
               chk({tag, "_rd"}, 32'(trace[j].rd), 32'd1);
               if (t < exp_q.size()) begin
                  chk({tag, "_data"}, 32'(trace[j].data), 32'(exp_q[t].data));
                  chk({tag, "_rs"},   32'(trace[j].rs),   32'(exp_q[t].rs));
               end else begin
                  chk({tag, "_unexpected_write"}, 32'(t), 32'(exp_q.size()));
               end
            end
            repeat ((n + P - 1) / P) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
         end
      end
      chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nruns, first, gap, wr_lows, cs_lows;
      bit saw_full, found;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;

      rst      = 1'b1;
      lcdPwr   = 1'b1;
      wrEn     = 1'b0;
      commAddr = '0;
      commData = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      step();

      // Reset state
      chk("rst_cs",    32'(lcdCs),     32'd1);
      chk("rst_wr",    32'(lcdWr),     32'd1);
      chk("rst_rd",    32'(lcdRd),     32'd1);
      chk("rst_rs",    32'(lcdRs),     32'd1);
      chk("rst_data",  32'(dispData),  32'd0);
      chk("rst_rdy",   32'(wrRdy),     32'd1);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_level", 32'(fifoLevel), 32'd0);

      // Single instruction write 0xA5
      trace.delete();
      exp_q.delete();
      push(3'd3, 8'hA5);
      chk("single_level", 32'(fifoLevel), 32'd1);
      chk("single_busy",  32'(busy),      32'd1);
      repeat (7) step();
      analyse("single", nruns, first, gap);
      chk("single_runs",  32'(nruns), 32'd1);
      chk("single_start", 32'(first), 32'd1);
      chk("single_busy_end",  32'(busy),      32'd0);
      chk("single_level_end", 32'(fifoLevel), 32'd0);

      // Random single writes
      for (int k = 0; k < 4; k++) begin
         trace.delete();
         exp_q.delete();
         a = ADDR_W'(2 + $urandom_range(0, 1));
         d = DATA_W'($urandom);
         push(a, d);
         repeat (7) step();
         analyse("rand_single", nruns, first, gap);
         chk("rand_single_runs", 32'(nruns), 32'd1);
      end

      // No-op addresses: handshake accepted, nothing queued, no bus cycle
      trace.delete();
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         case ($urandom_range(0, 5))
            0: a = 3'd0;
            1: a = 3'd1;
            2: a = 3'd4;
            3: a = 3'd5;
            4: a = 3'd6;
            default: a = 3'd7;
         endcase
         if (k == 0) a = 3'd5;
         chk("noop_rdy", 32'(wrRdy), 32'd1);
         push(a, DATA_W'($urandom));
         chk("noop_level", 32'(fifoLevel), 32'd0);
         chk("noop_busy",  32'(busy),      32'd0);
      end
      repeat (4) step();
      analyse("noop", nruns, first, gap);
      chk("noop_runs", 32'(nruns), 32'd0);

      // Asynchronous reset in the middle of a write
      push(3'd3, DATA_W'($urandom));
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_cs",    32'(lcdCs),     32'd1);
      chk("arst_wr",    32'(lcdWr),     32'd1);
      chk("arst_level", 32'(fifoLevel), 32'd0);
      chk("arst_busy",  32'(busy),      32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();

      // Continuous pushes until the FIFO fills, then drain
      trace.delete();
      exp_q.delete();
      saw_full = 1'b0;
      push(3'd2, DATA_W'($urandom));
      chk("fill_level_first", 32'(fifoLevel), 32'd1);
      push(3'd3, DATA_W'($urandom));
      chk("fill_level_pushpop", 32'(fifoLevel), 32'd1);
      for (int k = 0; k < 28; k++) begin
         chk("fill_rdy_vs_level", 32'(wrRdy), 32'(fifoLevel != LW'(FIFO_DEPTH)));
         chk("fill_level_max",    32'(fifoLevel <= LW'(FIFO_DEPTH)), 32'd1);
         if (!wrRdy) saw_full = 1'b1;
         a = ($urandom_range(0, 5) == 0) ? 3'd7 : ADDR_W'(2 + $urandom_range(0, 1));
         push(a, DATA_W'($urandom));
      end
      repeat (70) step();
      chk("fill_saw_full", 32'(saw_full), 32'd1);
      analyse("fill", nruns, first, gap);
      chk("fill_busy_end",  32'(busy),      32'd0);
      chk("fill_level_end", 32'(fifoLevel), 32'd0);

      // Power drop during the strobe, with a second write still queued
      trace.delete();
      exp_q.delete();
      push(3'd2, DATA_W'($urandom));
      push(3'd3, DATA_W'($urandom));
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (!lcdWr) found = 1'b1;
      end
      chk("pwr_strobe_seen", 32'(found), 32'd1);
      lcdPwr = 1'b0;
      #1;
      chk("pwr_cs",   32'(lcdCs),    32'd0);
      chk("pwr_wr",   32'(lcdWr),    32'd0);
      chk("pwr_rd",   32'(lcdRd),    32'd0);
      chk("pwr_rs",   32'(lcdRs),    32'd0);
      chk("pwr_data", 32'(dispData), 32'd0);
      chk("pwr_rdy",  32'(wrRdy),    32'd0);
      step();
      chk("pwr_level", 32'(fifoLevel), 32'd0);
      chk("pwr_busy",  32'(busy),      32'd0);
      lcdPwr = 1'b1;
      step();
      chk("pwron_cs",    32'(lcdCs),     32'd1);
      chk("pwron_wr",    32'(lcdWr),     32'd1);
      chk("pwron_rd",    32'(lcdRd),     32'd1);
      chk("pwron_data",  32'(dispData),  32'd0);
      chk("pwron_rdy",   32'(wrRdy),     32'd1);
      chk("pwron_level", 32'(fifoLevel), 32'd0);
      trace.delete();
      exp_q.delete();
      repeat (10) step();
      wr_lows = 0;
      cs_lows = 0;
      foreach (trace[k]) begin
         if (!trace[k].wr) wr_lows++;
         if (!trace[k].cs) cs_lows++;
      end
      chk("pwron_no_wr_pulse", 32'(wr_lows), 32'd0);
      chk("pwron_no_cs",       32'(cs_lows), 32'd0);

      // Two queued writes: burst keeps CS low, otherwise a 1-cycle gap
      trace.delete();
      exp_q.delete();
      push(3'd2, DATA_W'($urandom));
      push(3'd3, DATA_W'($urandom));
      repeat (15) step();
      analyse("pair", nruns, first, gap);
      chk("pair_runs", 32'(nruns), BURST ? 32'd1 : 32'd2);
      chk("pair_gap",  32'(gap),   BURST ? 32'hFFFF_FFFF : 32'd1);
      chk("pair_busy_end", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
